// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

   localparam int NREQ_DEF   = 4;
   localparam int DATA_W_DEF = 8;
   localparam int TMO_W_DEF  = 16;

   // Transaction sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } arb_state_t;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter handshake bundle around the UART transmit arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface uart_tx_arbiter_if
   import uart_arb_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int TMO_W  = TMO_W_DEF,
   parameter int IDX_W  = idx_width(NREQ)
) ();

   logic                     arb_en;
   logic [TMO_W-1:0]         tmo_limit;
   logic [NREQ-1:0]          req_valid;
   logic [NREQ*DATA_W-1:0]   req_data;
   logic [NREQ-1:0]          req_ready;
   logic                     uart_tx_en;
   logic [DATA_W-1:0]        uart_din;
   logic                     uart_tx_done;
   logic [IDX_W-1:0]         grant_id;
   logic                     busy;
   logic                     tmo_err;

   modport slave (
      input  arb_en, tmo_limit, req_valid, req_data, uart_tx_done,
      output req_ready, uart_tx_en, uart_din, grant_id, busy, tmo_err
   );

   modport master (
      output arb_en, tmo_limit, req_valid, req_data, uart_tx_done,
      input  req_ready, uart_tx_en, uart_din, grant_id, busy, tmo_err
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate a doubled request vector down by
// ptr, take the first set bit, then map the offset back to an absolute index.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int IDX_W = idx_width(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any
);

   localparam logic [IDX_W:0] NREQ_X = (IDX_W + 1)'(NREQ);

   logic [2*NREQ-1:0] w_dbl;
   logic [2*NREQ-1:0] w_rot;
   logic [IDX_W-1:0]  w_off;
   logic [IDX_W:0]    w_sum;

   assign w_dbl = {req, req};
   assign w_rot = w_dbl >> ptr;
   assign any   = |req;

   // Find the lowest set bit of the rotated window (scan high to low so the lowest wins).
   always_comb begin
      w_off = {IDX_W{1'b0}};
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = IDX_W'(i);
         end else begin
            w_off = w_off;
         end
      end
   end

   // Undo the rotation: absolute index is (ptr + offset) modulo NREQ.
   always_comb begin
      w_sum = {1'b0, ptr} + {1'b0, w_off};
      if (w_sum >= NREQ_X) begin
         gnt_idx = IDX_W'(w_sum - NREQ_X);
      end else begin
         gnt_idx = w_sum[IDX_W-1:0];
      end
   end

   // One-hot grant, empty when nobody is requesting.
   always_comb begin
      if (any) begin
         gnt = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
      end else begin
         gnt = {NREQ{1'b0}};
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte
// producers. One byte per transaction: grant in IDLE, strobe tx_en in LAUNCH,
// wait for tx_done (or a programmable timeout) in WAIT.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int TMO_W  = TMO_W_DEF
) (
   input  logic              PCLK,
   input  logic              PRESET,
   uart_tx_arbiter_if.slave  bus
);

   localparam int              IDX_W    = idx_width(NREQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
   localparam logic [TMO_W-1:0] CNT_MAX  = {TMO_W{1'b1}};
   localparam logic [TMO_W-1:0] CNT_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

   arb_state_t        r_state;
   logic [DATA_W-1:0] r_din;
   logic [IDX_W-1:0]  r_gid;
   logic [IDX_W-1:0]  r_ptr;
   logic [TMO_W-1:0]  r_cnt;
   logic              r_tx_en;
   logic              r_busy;
   logic              r_tmo_err;

   logic [NREQ-1:0]   w_gnt;
   logic [IDX_W-1:0]  w_gnt_idx;
   logic              w_any;
   logic [NREQ-1:0]   w_ready;
   logic [DATA_W-1:0] w_sel_data;
   logic [IDX_W-1:0]  w_ptr_next;
   logic              w_tmo_hit;

   rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req     (bus.req_valid),
      .ptr     (r_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx),
      .any     (w_any)
   );

   // Grant is offered only in IDLE with arbitration enabled, and never during reset.
   always_comb begin
      w_ready = {NREQ{1'b0}};
      if ((r_state == IDLE) && bus.arb_en && !PRESET) begin
         w_ready = w_gnt;
      end else begin
         w_ready = {NREQ{1'b0}};
      end
   end

   // Select the winning requester's byte from the packed data bus.
   always_comb begin
      w_sel_data = {DATA_W{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt_idx == IDX_W'(i)) begin
            w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
         end else begin
            w_sel_data = w_sel_data;
         end
      end
   end

   // Next search start: one past the current owner, wrapping at NREQ-1.
   always_comb begin
      if (r_gid == LAST_IDX) begin
         w_ptr_next = {IDX_W{1'b0}};
      end else begin
         w_ptr_next = r_gid + {{(IDX_W-1){1'b0}}, 1'b1};
      end
   end

   // Timeout fires on a compare match with the live limit, or once the
   // counter has saturated (covers a limit lowered below the current count).
   always_comb begin
      w_tmo_hit = 1'b0;
      if (bus.tmo_limit != {TMO_W{1'b0}}) begin
         w_tmo_hit = (r_cnt == (bus.tmo_limit - CNT_ONE)) || (r_cnt == CNT_MAX);
      end else begin
         w_tmo_hit = 1'b0;
      end
   end

   // Transaction FSM with registered launch/status outputs. tmo_err is
   // registered, so it appears in the first IDLE cycle after the aborting
   // WAIT cycle; a completion in that WAIT cycle therefore suppresses it.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state   <= IDLE;
         r_din     <= {DATA_W{1'b0}};
         r_gid     <= {IDX_W{1'b0}};
         r_ptr     <= {IDX_W{1'b0}};
         r_cnt     <= {TMO_W{1'b0}};
         r_tx_en   <= 1'b0;
         r_busy    <= 1'b0;
         r_tmo_err <= 1'b0;
      end else begin
         r_tx_en   <= 1'b0;
         r_tmo_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.arb_en && w_any) begin
                  r_din   <= w_sel_data;
                  r_gid   <= w_gnt_idx;
                  r_tx_en <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= LAUNCH;
               end else begin
                  r_state <= IDLE;
               end
            end
            LAUNCH: begin
               r_cnt   <= {TMO_W{1'b0}};
               r_state <= WAIT;
            end
            WAIT: begin
               if (bus.uart_tx_done) begin
                  r_busy  <= 1'b0;
                  r_ptr   <= w_ptr_next;
                  r_state <= IDLE;
               end else if (w_tmo_hit) begin
                  r_busy    <= 1'b0;
                  r_tmo_err <= 1'b1;
                  r_ptr     <= w_ptr_next;
                  r_state   <= IDLE;
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + CNT_ONE;
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = w_ready;
   assign bus.uart_tx_en = r_tx_en;
   assign bus.uart_din   = r_din;
   assign bus.grant_id   = r_gid;
   assign bus.busy       = r_busy;
   assign bus.tmo_err    = r_tmo_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NREQ=4, DATA_W=8, TMO_W=16.
module tb_uart_tx_arbiter;

   logic PCLK   = 1'b0;
   logic PRESET = 1'b1;

   uart_tx_arbiter_if #(.NREQ(4), .DATA_W(8), .TMO_W(16)) bus ();

   uart_tx_arbiter #(.NREQ(4), .DATA_W(8), .TMO_W(16)) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (bus)
   );

   always #5 PCLK = ~PCLK;

   // Bytes presented by requesters 0..3.
   logic [7:0] dtab [4] = '{8'hB0, 8'hA5, 8'hC2, 8'hD3};

   int n_chk = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic cyc();
      @(posedge PCLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      bit saw_tmo;
      bit lost_busy;

      bus.arb_en       = 1'b1;
      bus.tmo_limit    = 16'd0;
      bus.req_valid    = 4'b0000;
      bus.req_data     = {dtab[3], dtab[2], dtab[1], dtab[0]};
      bus.uart_tx_done = 1'b0;

      // ---- reset state (req_valid raised to prove req_ready is gated) ----
      cyc();
      cyc();
      bus.req_valid = 4'b1111;
      #1;
      check_val("rst_ready", 32'(bus.req_ready), 32'h0);
      check_val("rst_tx_en", 32'(bus.uart_tx_en), 32'h0);
      check_val("rst_din", 32'(bus.uart_din), 32'h0);
      check_val("rst_gid", 32'(bus.grant_id), 32'h0);
      check_val("rst_busy", 32'(bus.busy), 32'h0);
      check_val("rst_tmo", 32'(bus.tmo_err), 32'h0);
      bus.req_valid = 4'b0000;
      PRESET = 1'b0;
      cyc();

      // ---- single requester ----
      bus.req_valid = 4'b0010;
      #1;
      check_val("single_ready", 32'(bus.req_ready), 32'h2);
      cyc();
      bus.req_valid = 4'b0000;
      #1;
      check_val("single_tx_en", 32'(bus.uart_tx_en), 32'h1);
      check_val("single_din", 32'(bus.uart_din), 32'hA5);
      check_val("single_gid", 32'(bus.grant_id), 32'h1);
      check_val("single_busy", 32'(bus.busy), 32'h1);
      check_val("single_ready_off", 32'(bus.req_ready), 32'h0);
      cyc();
      check_val("single_tx_en_1cyc", 32'(bus.uart_tx_en), 32'h0);
      bus.uart_tx_done = 1'b1;
      cyc();
      bus.uart_tx_done = 1'b0;
      check_val("single_busy_drop", 32'(bus.busy), 32'h0);

      // ---- fairness from a fresh pointer ----
      PRESET = 1'b1;
      cyc();
      PRESET = 1'b0;
      bus.req_valid = 4'b1111;
      found = 1'b0;
      for (int w = 0; w < 20 && !found; w++) begin
         cyc();
         if (bus.uart_tx_en) found = 1'b1;
      end
      check_val("fair_first_launch", 32'(found), 32'h1);
      for (int k = 0; k < 6; k++) begin
         check_val("fair_gid", 32'(bus.grant_id), 32'(k % 4));
         check_val("fair_din", 32'(bus.uart_din), 32'(dtab[k % 4]));
         repeat (10) cyc();
         check_val("fair_busy_wait", 32'(bus.busy), 32'h1);
         bus.uart_tx_done = 1'b1;
         if (k == 5) bus.req_valid = 4'b0000;
         cyc();
         bus.uart_tx_done = 1'b0;
         check_val("fair_idle_d1", 32'(bus.busy), 32'h0);
         if (k < 5) begin
            #1;
            check_val("fair_ready", 32'(bus.req_ready), 32'(4'b0001 << ((k + 1) % 4)));
            cyc();
            check_val("fair_b2b_launch", 32'(bus.uart_tx_en), 32'h1);
         end
      end

      // ---- timeout, limit 5; pointer is now 2 ----
      bus.tmo_limit = 16'd5;
      bus.req_valid = 4'b1111;
      #1;
      check_val("tmo_ready", 32'(bus.req_ready), 32'h4);
      cyc();
      check_val("tmo_gid", 32'(bus.grant_id), 32'h2);
      for (int w = 1; w <= 5; w++) begin
         cyc();
         check_val("tmo_wait_quiet", 32'(bus.tmo_err), 32'h0);
         check_val("tmo_wait_busy", 32'(bus.busy), 32'h1);
      end
      cyc();
      check_val("tmo_pulse", 32'(bus.tmo_err), 32'h1);
      check_val("tmo_busy_drop", 32'(bus.busy), 32'h0);
      check_val("tmo_next_ready", 32'(bus.req_ready), 32'h8);
      cyc();
      check_val("tmo_next_gid", 32'(bus.grant_id), 32'h3);
      check_val("tmo_pulse_end", 32'(bus.tmo_err), 32'h0);

      // ---- limit 0 waits indefinitely; arb_en dropped mid-transaction ----
      bus.tmo_limit = 16'd0;
      bus.arb_en    = 1'b0;
      saw_tmo   = 1'b0;
      lost_busy = 1'b0;
      repeat (40) begin
         cyc();
         if (bus.tmo_err) saw_tmo = 1'b1;
         if (!bus.busy) lost_busy = 1'b1;
      end
      check_val("nolimit_no_tmo", 32'(saw_tmo), 32'h0);
      check_val("nolimit_busy", 32'(lost_busy), 32'h0);
      bus.uart_tx_done = 1'b1;
      cyc();
      bus.uart_tx_done = 1'b0;
      #1;
      check_val("gate_done_busy", 32'(bus.busy), 32'h0);
      check_val("gate_no_ready", 32'(bus.req_ready), 32'h0);
      repeat (3) cyc();
      check_val("gate_no_launch", 32'(bus.uart_tx_en), 32'h0);
      check_val("gate_still_idle", 32'(bus.req_ready), 32'h0);
      bus.arb_en = 1'b1;
      #1;
      check_val("gate_resume_wrap", 32'(bus.req_ready), 32'h1);

      // ---- stray tx_done in IDLE/LAUNCH, then done and timeout together ----
      bus.uart_tx_done = 1'b1;
      bus.tmo_limit    = 16'd3;
      cyc();
      check_val("stray_gid", 32'(bus.grant_id), 32'h0);
      cyc();
      bus.uart_tx_done = 1'b0;
      bus.req_valid    = 4'b0000;
      check_val("stray_busy_w1", 32'(bus.busy), 32'h1);
      cyc();
      check_val("stray_busy_w2", 32'(bus.busy), 32'h1);
      cyc();
      bus.uart_tx_done = 1'b1;
      cyc();
      bus.uart_tx_done = 1'b0;
      check_val("tie_busy", 32'(bus.busy), 32'h0);
      check_val("tie_no_tmo", 32'(bus.tmo_err), 32'h0);

      // ---- reset in WAIT; pointer is now 1 ----
      bus.tmo_limit = 16'd0;
      bus.req_valid = 4'b1001;
      #1;
      check_val("rw_ready", 32'(bus.req_ready), 32'h8);
      cyc();
      check_val("rw_gid", 32'(bus.grant_id), 32'h3);
      cyc();
      PRESET = 1'b1;
      #1;
      check_val("rw_busy", 32'(bus.busy), 32'h0);
      check_val("rw_gid0", 32'(bus.grant_id), 32'h0);
      check_val("rw_din0", 32'(bus.uart_din), 32'h0);
      check_val("rw_tx_en0", 32'(bus.uart_tx_en), 32'h0);
      check_val("rw_ready0", 32'(bus.req_ready), 32'h0);
      PRESET = 1'b0;
      #1;
      check_val("rw_first_ready", 32'(bus.req_ready), 32'h1);
      cyc();
      check_val("rw_first_gid", 32'(bus.grant_id), 32'h0);
      check_val("rw_first_din", 32'(bus.uart_din), 32'hB0);
      check_val("rw_first_tx_en", 32'(bus.uart_tx_en), 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter between up to `NREQ` byte-producing requesters (APB register path, DMA-style sources, debug port). It sits between the requesters and the transmitter's `tx_en`/`din`/`tx_done` interface. It serialises requests into one-byte transactions, launches each one, and waits for completion. A programmable timeout recovers from a hung transmitter.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, byte width
- `TMO_W`, 16, timeout counter width

Ports:
- `PCLK`  in  1  single clock, rising edge
- `PRESET`  in  1  asynchronous, active-high reset
- `arb_en`  in  1  when low, no new grants; an in-flight byte still completes
- `tmo_limit`  in  TMO_W  WAIT-state cycle limit; 0 disables the timeout
- `req_valid`  in  NREQ  requester i has a byte pending
- `req_data`  in  NREQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
- `req_ready`  out  NREQ  one-hot grant; the byte is accepted when `req_valid[i] & req_ready[i]`
- `uart_tx_en`  out  1  one-cycle launch strobe to the transmitter
- `uart_din`  out  DATA_W  byte to transmit; held stable from launch until the transaction ends
- `uart_tx_done`  in  1  transmitter completion pulse
- `grant_id`  out  $clog2(NREQ)  index of the requester owning the current transaction
- `busy`  out  1  high in LAUNCH or WAIT
- `tmo_err`  out  1  one-cycle pulse when a transaction is aborted by timeout

## Operation
- FSM states: IDLE, LAUNCH, WAIT.
- **IDLE**
  - If `arb_en` is high and any `req_valid` bit is set, pick the winner by round-robin, starting the search at `ptr` (lowest index ≥ `ptr` first, then wrap to 0).
  - Assert `req_ready[winner]` combinationally in this cycle.
  - On the clock edge: capture `req_data[winner]` into `uart_din`, capture `winner` into `grant_id`, go to LAUNCH.
  - `req_ready` is only ever high in IDLE. A requester that drops `valid` causes no grant.
- **LAUNCH**
  - `uart_tx_en`=1 for exactly this cycle.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - `uart_tx_done`=1 → go to IDLE and set `ptr` = `grant_id`+1. The increment wraps modulo `NREQ`; for non-power-of-2 `NREQ`, `NREQ-1` wraps to 0.
  - Else if `tmo_limit`≠0 and the counter equals `tmo_limit`-1 → pulse `tmo_err`, go to IDLE, advance `ptr` as above.
  - Else increment the counter. It saturates and never wraps.
- `uart_tx_done` is ignored in IDLE and LAUNCH.
- `arb_en` falling during LAUNCH or WAIT has no effect on the current transaction.
- `tmo_limit` is sampled every WAIT cycle. Lowering it below the current count aborts on the next compare match or at saturation, whichever comes first.
- Reset mid-operation: the FSM returns to IDLE immediately, and the launched byte is abandoned. The transmitter is reset by the same reset.

## Timing
- Reset values: `req_ready`=0, `uart_tx_en`=0, `uart_din`=0, `grant_id`=0, `busy`=0, `tmo_err`=0, `ptr`=0, counter=0.
- Grant-to-launch latency: `req_ready` in cycle t, `uart_tx_en` in cycle t+1.
- `busy`: high from t+1 until the cycle in which `tx_done` or the timeout is seen (inclusive).
- Back-to-back: `tx_done` in cycle d → IDLE in d+1 (next grant possible) → next `uart_tx_en` in d+2.
- Timeout with limit L: `tmo_err` is asserted on the L-th WAIT cycle after LAUNCH.
- All outputs are registered except `req_ready`, which is decoded from state, `arb_en`, `req_valid` and `ptr`.

## Structure
- Package `uart_arb_pkg`: state enum (IDLE, LAUNCH, WAIT) and default parameter constants.
- One sub-module, `rr_pick`: combinational round-robin priority picker.
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot `gnt`, `gnt_idx`, `any`.
  - Implemented as a double-width vector rotate-and-find-first.
- Top level holds the FSM, the data/grant-id registers, the pointer and the timeout counter.

## Test plan
- Single requester: req_valid=4'b0010, data=8'hA5 → `req_ready`=4'b0010 for 1 cycle; `uart_tx_en` 1 cycle later with `uart_din`=8'hA5, `grant_id`=1; `tx_done` → `busy` drops.
- Fairness: all four requesters held valid, with `tx_done` 10 cycles after each launch → grant order 0,1,2,3,0,1; exactly 2 cycles from each `tx_done` to the next `uart_tx_en`.
- Timeout: tmo_limit=5, `tx_done` never sent → `tmo_err` pulses on the 5th WAIT cycle; next grant goes to requester `grant_id`+1. With tmo_limit=0 the block waits indefinitely.
- Gating: `arb_en` dropped during WAIT → current byte completes on `tx_done`; no `req_ready` while `arb_en`=0; grants resume when it returns high.
- Stray/simultaneous events: `tx_done` pulsed in IDLE or LAUNCH → ignored. `tx_done` and timeout on the same WAIT cycle → completion wins, no `tmo_err`.
- Reset in WAIT: `PRESET` pulsed → all outputs 0 in the same cycle; first grant after reset goes to the lowest-indexed valid requester.
